// File: rtl/axis_width_down_conv.sv
// rtl/axis_width_down_conv.sv - AXI-Stream byte-width down-converter with sparse tkeep packing
module axis_width_down_conv #(
    parameter int IN_BYTES  = 4,
    parameter int OUT_BYTES = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [8*IN_BYTES-1:0]  axis_tdata_in,
    input  logic [IN_BYTES-1:0]    axis_tkeep_in,
    input  logic                   axis_tvalid_in,
    input  logic                   axis_tlast_in,
    output logic                   axis_tready_out,
    output logic [8*OUT_BYTES-1:0] axis_tdata_out,
    output logic [OUT_BYTES-1:0]   axis_tkeep_out,
    output logic                   axis_tvalid_out,
    output logic                   axis_tlast_out,
    input  logic                   axis_tready_in
);
    localparam int R  = IN_BYTES / OUT_BYTES;
    localparam int OW = 8 * OUT_BYTES;

    logic [8*IN_BYTES-1:0] data_q;
    logic [IN_BYTES-1:0]   rem_keep_q;
    logic                  last_q;
    logic                  full_q;

    logic                  found;
    logic                  more;
    logic [OW-1:0]         cur_data;
    logic [OUT_BYTES-1:0]  cur_keep;
    logic [IN_BYTES-1:0]   clr_mask;
    logic                  in_xfer;
    logic                  out_xfer;

    // Lowest nonzero keep slice is emitted; any further nonzero slice means more to come.
    always_comb begin
        found    = 1'b0;
        more     = 1'b0;
        cur_data = '0;
        cur_keep = '0;
        clr_mask = '0;
        for (int i = 0; i < R; i++) begin
            if (rem_keep_q[i*OUT_BYTES +: OUT_BYTES] != '0) begin
                if (!found) begin
                    found    = 1'b1;
                    cur_data = data_q[i*OW +: OW];
                    cur_keep = rem_keep_q[i*OUT_BYTES +: OUT_BYTES];
                    clr_mask[i*OUT_BYTES +: OUT_BYTES] = '1;
                end else begin
                    more = 1'b1;
                end
            end
        end
    end

    // A null terminator (full with rem_keep zero) has found=0 and so drives zero data.
    assign axis_tvalid_out = full_q;
    assign axis_tdata_out  = cur_data;
    assign axis_tkeep_out  = cur_keep;
    assign axis_tlast_out  = full_q & last_q & ~more;

    assign out_xfer        = full_q & axis_tready_in;
    assign axis_tready_out = reset_n & (~full_q | (out_xfer & ~more));
    assign in_xfer         = axis_tvalid_in & axis_tready_out;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q     <= '0;
            rem_keep_q <= '0;
            last_q     <= 1'b0;
            full_q     <= 1'b0;
        end else if (in_xfer) begin
            data_q     <= axis_tdata_in;
            rem_keep_q <= axis_tkeep_in;
            last_q     <= axis_tlast_in;
            full_q     <= (|axis_tkeep_in) | axis_tlast_in;
        end else if (out_xfer) begin
            rem_keep_q <= rem_keep_q & ~clr_mask;
            if (!more) begin
                full_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_width_down_conv.sv
// tb/tb_axis_width_down_conv.sv - scoreboard bench for axis_width_down_conv (4->1 and 8->2)
module tb_axis_width_down_conv;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] din1;
    logic [3:0]  kin1;
    logic        vin1, lin1, rdy_out1;
    logic [7:0]  dout1;
    logic [0:0]  kout1;
    logic        vout1, lout1, rdy_in1;

    logic [63:0] din2;
    logic [7:0]  kin2;
    logic        vin2, lin2, rdy_out2;
    logic [15:0] dout2;
    logic [1:0]  kout2;
    logic        vout2, lout2;
    logic        rdy_in2 = 1'b1;

    axis_width_down_conv #(.IN_BYTES(4), .OUT_BYTES(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .axis_tdata_in(din1), .axis_tkeep_in(kin1), .axis_tvalid_in(vin1),
        .axis_tlast_in(lin1), .axis_tready_out(rdy_out1),
        .axis_tdata_out(dout1), .axis_tkeep_out(kout1), .axis_tvalid_out(vout1),
        .axis_tlast_out(lout1), .axis_tready_in(rdy_in1)
    );

    axis_width_down_conv #(.IN_BYTES(8), .OUT_BYTES(2)) dut2 (
        .clk(clk), .reset_n(reset_n),
        .axis_tdata_in(din2), .axis_tkeep_in(kin2), .axis_tvalid_in(vin2),
        .axis_tlast_in(lin2), .axis_tready_out(rdy_out2),
        .axis_tdata_out(dout2), .axis_tkeep_out(kout2), .axis_tvalid_out(vout2),
        .axis_tlast_out(lout2), .axis_tready_in(rdy_in2)
    );

    typedef struct {
        logic [15:0] d;
        logic [1:0]  k;
        logic        l;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push1(input logic [7:0] d, input logic l);
        q1.push_back('{d: {8'h00, d}, k: 2'b01, l: l});
    endtask

    // Ready source: fixed level or 50% random stalls, applied just after negedge.
    logic rdy_base = 1'b1;
    logic stall_en = 1'b0;
    always begin
        @(negedge clk);
        #1;
        rdy_in1 = stall_en ? 1'(($urandom_range(0, 1))) : rdy_base;
    end

    // Monitor for the 4->1 instance, sampled 1 ns before the active edge.
    logic       held1 = 1'b0;
    logic [9:0] hold1;
    exp_t       e1;
    always begin
        @(negedge clk);
        #4;
        if (!reset_n) begin
            held1 = 1'b0;
        end else begin
            if (held1) chk("stall_hold", {21'b0, vout1, dout1, kout1, lout1}, {21'b0, 1'b1, hold1});
            if (vout1 && rdy_in1) begin
                held1 = 1'b0;
                if (q1.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out1_unexpected: got d=%h k=%b l=%b expected none", dout1, kout1, lout1);
                end else begin
                    e1 = q1.pop_front();
                    chk("out1", {22'b0, dout1, kout1, lout1}, {22'b0, e1.d[7:0], e1.k[0], e1.l});
                end
            end else if (vout1) begin
                held1 = 1'b1;
                hold1 = {dout1, kout1, lout1};
            end else begin
                held1 = 1'b0;
            end
        end
    end

    exp_t e2;
    always begin
        @(negedge clk);
        #4;
        if (reset_n && vout2 && rdy_in2) begin
            if (q2.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL out2_unexpected: got d=%h k=%b l=%b expected none", dout2, kout2, lout2);
            end else begin
                e2 = q2.pop_front();
                chk("out2", {13'b0, dout2, kout2, lout2}, {13'b0, e2.d, e2.k, e2.l});
            end
        end
    end

    task automatic send1(input logic [31:0] d, input logic [3:0] k, input logic l, output int c);
        logic ok;
        ok = 1'b0;
        @(negedge clk);
        din1 = d; kin1 = k; lin1 = l; vin1 = 1'b1;
        for (int n = 0; n < 300; n++) begin
            #4;
            if (rdy_out1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("in1_accept", {31'b0, ok}, 32'd1);
        @(posedge clk);
        c = cyc;
    endtask

    task automatic idle1();
        @(negedge clk);
        vin1 = 1'b0;
    endtask

    task automatic drain1();
        for (int n = 0; n < 400; n++) begin
            if (q1.size() == 0) break;
            @(negedge clk);
        end
        chk("drain1", q1.size(), 32'd0);
    endtask

    int c1, c2;

    initial begin
        reset_n = 1'b0;
        din1 = '0; kin1 = '0; lin1 = 1'b0; vin1 = 1'b0;
        din2 = '0; kin2 = '0; lin2 = 1'b0; vin2 = 1'b0;
        repeat (3) @(negedge clk);
        #4;
        chk("reset_state", {26'b0, vout1, rdy_out1, kout1, lout1, vout2, rdy_out2}, 32'd0);
        chk("reset_data", {24'b0, dout1}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Full beats: 00..07, tlast only on 07, second beat accepted 4 cycles after the first.
        for (int i = 0; i < 8; i++) push1(8'(i), i == 7);
        send1(32'h03020100, 4'hF, 1'b0, c1);
        send1(32'h07060504, 4'hF, 1'b1, c2);
        idle1();
        chk("accept_gap", c2 - c1, 32'd4);
        drain1();

        // Sparse keep.
        push1(8'hA5, 1'b0);
        push1(8'hA5, 1'b0);
        send1(32'hA5A5A5A5, 4'hA, 1'b0, c1);
        push1(8'h11, 1'b0);
        push1(8'h33, 1'b0);
        push1(8'h44, 1'b1);
        send1(32'h44332211, 4'hD, 1'b1, c1);
        idle1();
        drain1();

        // Null terminator, then a dropped all-zero beat followed by a normal packet.
        for (int i = 0; i < 4; i++) push1(8'h50 + 8'(i), 1'b0);
        send1(32'h53525150, 4'hF, 1'b0, c1);
        q1.push_back('{d: 16'h0000, k: 2'b00, l: 1'b1});
        send1(32'hDEADBEEF, 4'h0, 1'b1, c1);
        send1(32'hCAFEF00D, 4'h0, 1'b0, c1);
        for (int i = 0; i < 4; i++) push1(8'h60 + 8'(i), i == 3);
        send1(32'h63626160, 4'hF, 1'b1, c1);
        idle1();
        drain1();

        // Backpressure: same traffic as above under random stalls.
        stall_en = 1'b1;
        for (int i = 0; i < 8; i++) push1(8'(i), i == 7);
        send1(32'h03020100, 4'hF, 1'b0, c1);
        send1(32'h07060504, 4'hF, 1'b1, c1);
        push1(8'hA5, 1'b0);
        push1(8'hA5, 1'b0);
        send1(32'hA5A5A5A5, 4'hA, 1'b0, c1);
        push1(8'h11, 1'b0);
        push1(8'h33, 1'b0);
        push1(8'h44, 1'b1);
        send1(32'h44332211, 4'hD, 1'b1, c1);
        idle1();
        drain1();
        stall_en = 1'b0;
        rdy_base = 1'b1;

        // Wider output on the 8->2 instance.
        q2.push_back('{d: 16'h3322, k: 2'b11, l: 1'b0});
        q2.push_back('{d: 16'h5544, k: 2'b11, l: 1'b1});
        begin
            logic ok2;
            ok2 = 1'b0;
            @(negedge clk);
            din2 = 64'h7766554433221100; kin2 = 8'h3C; lin2 = 1'b1; vin2 = 1'b1;
            for (int n = 0; n < 50; n++) begin
                #4;
                if (rdy_out2) begin
                    ok2 = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("in2_accept", {31'b0, ok2}, 32'd1);
            @(negedge clk);
            vin2 = 1'b0;
            for (int n = 0; n < 50; n++) begin
                if (q2.size() == 0) break;
                @(negedge clk);
            end
            chk("drain2", q2.size(), 32'd0);
        end

        // Reset after the second byte of a 4-byte beat.
        push1(8'h10, 1'b0);
        push1(8'h11, 1'b0);
        send1(32'h13121110, 4'hF, 1'b0, c1);
        idle1();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        rdy_base = 1'b0;
        chk("rst_q_empty", q1.size(), 32'd0);
        @(negedge clk);
        #4;
        chk("mid_reset", {28'b0, vout1, rdy_out1, kout1, lout1}, 32'd0);
        chk("mid_reset_data", {24'b0, dout1}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rdy_base = 1'b1;
        for (int i = 0; i < 4; i++) push1(8'h20 + 8'(i), i == 3);
        send1(32'h23222120, 4'hF, 1'b1, c1);
        idle1();
        drain1();
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/axis_width_down_conv.md
# axis_width_down_conv

Parametrised single-clock AXI-Stream byte-width down-converter for the UDP datapath, generalising the fixed 32-to-8 converter. It takes IN_BYTES-wide beats with tkeep/tlast and emits OUT_BYTES-wide beats lowest lane first. Sub-words whose tkeep is all zero are skipped, so sparse input beats pack without bubbles. It sits between the SRIO/UDP packet logic and narrower MAC/FIFO consumers.

## Interface
- IN_BYTES, 4: input width in bytes; must be an integer multiple of OUT_BYTES.
- OUT_BYTES, 1: output width in bytes.
- R (localparam), IN_BYTES/OUT_BYTES: number of sub-words per input beat; must be 2 or more.
- clk  in  1  single clock for the whole block.
- reset_n  in  1  synchronous, active-low reset.
- axis_tdata_in  in  8*IN_BYTES  input data; byte 0 is bits [7:0].
- axis_tkeep_in  in  IN_BYTES  input byte-valid mask.
- axis_tvalid_in  in  1  input valid.
- axis_tlast_in  in  1  input end of packet.
- axis_tready_out  out  1  input ready.
- axis_tdata_out  out  8*OUT_BYTES  output data.
- axis_tkeep_out  out  OUT_BYTES  output byte-valid mask.
- axis_tvalid_out  out  1  output valid.
- axis_tlast_out  out  1  output end of packet.
- axis_tready_in  in  1  downstream ready.

## Operation
- **Storage:** one holding register with these fields: data, rem_keep (IN_BYTES bits, still to be sent), last, full.
- **Sub-word keep:** sub-word i covers bytes [i*OUT_BYTES +: OUT_BYTES]. Its keep is the matching slice of rem_keep.
- **Selection:** the current sub-word is the lowest i whose keep slice is nonzero.
  - axis_tdata_out is that data slice; axis_tkeep_out is that keep slice.
  - Unused bytes inside an emitted sub-word pass through unmodified; tkeep marks them.
- **Handshake out:** axis_tvalid_out = full. A transfer happens when axis_tvalid_out and axis_tready_in are both high; it clears that sub-word's slice in rem_keep.
- **tlast:** axis_tlast_out = last AND no other nonzero slice remains above the current one.
- **Final sub-word:** the transfer that leaves rem_keep zero empties the register. If an input transfer happens in the same cycle, the register reloads instead.
- **Input ready:** axis_tready_out = reset_n AND (NOT full OR final sub-word transferring this cycle). This gives back-to-back packing at one output beat per cycle.
- **Load:** an input transfer (axis_tvalid_in AND axis_tready_out) loads data, keep, last and sets full.
- **All-zero tkeep, tlast=0:** the beat is accepted and dropped; full stays 0.
- **All-zero tkeep, tlast=1:** the register holds a null terminator. It emits one beat with tdata 0, tkeep 0, tlast 1. full is held until that beat transfers.
- **Backpressure:** while axis_tready_in is low, axis_tdata_out, axis_tkeep_out and axis_tlast_out stay stable. axis_tvalid_out stays high (AXI-S compliant).
- **Reset (reset_n=0 at a clk edge):**
  - full=0, rem_keep=0, last=0.
  - axis_tvalid_out=0, axis_tlast_out=0, axis_tkeep_out=0, axis_tdata_out=0.
  - axis_tready_out=0 while reset_n is low.
  - A beat in flight mid-reset is discarded; there is no partial output after release.

## Timing
- Latency: an input accepted at edge n gives its first output valid from edge n onward, i.e. registered with one cycle of latency.
- Throughput: one output sub-word per cycle while axis_tready_in=1.
  - A fully kept input beat occupies R cycles.
  - A beat with k nonzero sub-words occupies k cycles.
- axis_tready_out depends combinationally on axis_tready_in (final-sub-word bypass). There is no combinational path from axis_tvalid_in to any output.
- First input acceptance is possible on the first edge after reset_n is sampled high.

## Test plan
- **Full beats:** IN_BYTES=4, OUT_BYTES=1, tkeep=F, data 0x03020100 then 0x07060504 (tlast), axis_tready_in=1 -> output bytes 00..07 on consecutive cycles, tlast only on 07, axis_tready_out low for 3 of every 4 cycles.
- **Sparse keep:** data 0xA5A5A5A5 with tkeep=A -> exactly two output beats of A5 (lanes 1, 3). With tkeep=D and tlast -> three beats, tlast on the lane-3 byte.
- **Null terminator:** a tlast beat with tkeep=0 after a full beat -> four bytes, then one beat with tkeep=0, tlast=1. A tkeep=0, tlast=0 beat produces no output.
- **Backpressure:** toggle axis_tready_in randomly at 50% -> output byte sequence identical to the no-stall run, outputs stable while stalled, no beat lost or duplicated.
- **Wider output:** IN_BYTES=8, OUT_BYTES=2, tkeep=0x3C, tlast -> two beats (bytes 2-3, 4-5), each tkeep=3, tlast on the second.
- **Reset mid-beat:** assert reset_n=0 after the second byte of a 4-byte beat -> next edge gives valid=0 and axis_tready_out=0. After release, a new beat outputs from byte 0 with no residue.
